// File: rtl/uart_cmd_pkg.sv
// UART command set shared by the command decoder and the flash read sequencer:
// command bytes, sequencer state encoding and the reply checksum.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_SETIMG = 8'h53;
    localparam logic [7:0] CMD_GETIMG = 8'h43;
    localparam logic [7:0] CMD_RDSR   = 8'h52;
    localparam logic [7:0] CMD_RDCR   = 8'h45;
    localparam logic [7:0] CMD_WRCR   = 8'h47;
    localparam logic [7:0] CMD_ADDR   = 8'h41;
    localparam logic [7:0] CMD_RDDATA = 8'h56;
    localparam logic [7:0] CMD_WRDATA = 8'h4B;

    typedef enum logic [3:0] {
        IDLE,
        CHECK,
        HDR_CMD,
        HDR_LEN,
        RD_REQ,
        RD_WAIT,
        SER,
        CSUM,
        FIN
    } fsm_state_e;

    // Reply trailer: one's complement of the running byte sum.
    function automatic logic [7:0] checksum(input logic [7:0] sum);
        return ~sum;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Splits a 32-bit flash word into four bytes, LSB first, over valid/ready,
// and keeps the mod-256 sum of every reply byte the top reports as sent.
module word_serializer
    import uart_cmd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        ready_i,
    output logic [7:0]  byte_o,
    output logic        valid_o,
    output logic        last_o,
    input  logic        sum_clr_i,
    input  logic        sum_en_i,
    input  logic [7:0]  sum_byte_i,
    output logic [7:0]  sum_o
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic        full_q;
    logic [7:0]  sum_q;

    assign byte_o  = word_q[{idx_q, 3'b000} +: 8];
    assign valid_o = full_q;
    assign last_o  = full_q && ready_i && (idx_q == 2'd3);
    assign sum_o   = sum_q;

    // A load in the same cycle as the last byte's handshake wins, so words
    // can follow each other without an empty cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
            sum_q  <= '0;
        end else begin
            if (load_i) begin
                word_q <= word_i;
                idx_q  <= '0;
                full_q <= 1'b1;
            end else if (full_q && ready_i) begin
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) full_q <= 1'b0;
            end
            if (sum_clr_i)     sum_q <= '0;
            else if (sum_en_i) sum_q <= sum_q + sum_byte_i;
        end
    end

endmodule

// File: rtl/flash_read_sequencer.sv
// Reads UFM words over Avalon-MM for the read-data command and frames the reply.
// Define FLASH_RD_PREFETCH_EN to fetch word n+1 while word n is being sent.
module flash_read_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W   = 17,
    parameter logic [7:0]  RD_CMD   = CMD_RDDATA,
    parameter int unsigned WAIT_MAX = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [23:0]       start_addr,
    input  logic [7:0]        word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned       WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_MAX - 1);

    fsm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        len_q, len_d;
    logic              bad_q, bad_d;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic        ser_load, ser_valid, ser_last, ser_ready;
    logic        sum_clr, sum_en;
    logic [7:0]  ser_byte, sum;
    logic [31:0] ser_word;

`ifdef FLASH_RD_PREFETCH_EN
    logic        pf_req_q, pf_req_d;
    logic        pf_wait_q, pf_wait_d;
    logic        hold_v_q, hold_v_d;
    logic [31:0] hold_q, hold_d;
    logic        ser_from_hold;

    assign ser_word = ser_from_hold ? hold_q : avm_readdata;
`else
    assign ser_word = avm_readdata;
`endif

    assign ser_ready = tx_ready && (state_q == SER);
    assign sum_en    = tx_valid && tx_ready && (state_q != CSUM);

    word_serializer u_ser (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ser_load),
        .word_i     (ser_word),
        .ready_i    (ser_ready),
        .byte_o     (ser_byte),
        .valid_o    (ser_valid),
        .last_o     (ser_last),
        .sum_clr_i  (sum_clr),
        .sum_en_i   (sum_en),
        .sum_byte_i (tx_data),
        .sum_o      (sum)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        bad_d       = bad_q;
        err_d       = err_q;
        wait_d      = wait_q;
        busy        = 1'b1;
        done        = 1'b0;
        error       = 1'b0;
        avm_read    = 1'b0;
        avm_address = addr_q;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        ser_load    = 1'b0;
        sum_clr     = 1'b0;
`ifdef FLASH_RD_PREFETCH_EN
        pf_req_d      = pf_req_q;
        pf_wait_d     = pf_wait_q;
        hold_v_d      = hold_v_q;
        hold_d        = hold_q;
        ser_from_hold = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    addr_d  = start_addr[ADDR_W-1:0];
                    bad_d   = |(start_addr >> ADDR_W);
                    cnt_d   = (word_count == 8'd0) ? 9'd256 : {1'b0, word_count};
                    len_d   = word_count;
                    err_d   = 1'b0;
                    sum_clr = 1'b1;
                    state_d = CHECK;
`ifdef FLASH_RD_PREFETCH_EN
                    pf_req_d  = 1'b0;
                    pf_wait_d = 1'b0;
                    hold_v_d  = 1'b0;
`endif
                end
            end
            CHECK: begin
                if (bad_q) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = HDR_CMD;
                end
            end
            HDR_CMD: begin
                tx_valid = 1'b1;
                tx_data  = RD_CMD;
                if (tx_ready) state_d = HDR_LEN;
            end
            HDR_LEN: begin
                tx_valid = 1'b1;
                tx_data  = len_q;
                if (tx_ready) state_d = RD_REQ;
            end
            RD_REQ: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    wait_d  = WAIT_LOAD;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    ser_load = 1'b1;
                    state_d  = SER;
`ifdef FLASH_RD_PREFETCH_EN
                    pf_req_d = (cnt_q > 9'd1);
`endif
                end else if (wait_q == '0) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            SER: begin
                tx_valid = ser_valid;
                tx_data  = ser_byte;
`ifdef FLASH_RD_PREFETCH_EN
                avm_read    = pf_req_q;
                avm_address = addr_q + ADDR_W'(1);
                if (pf_req_q && !avm_waitrequest) begin
                    pf_req_d  = 1'b0;
                    pf_wait_d = 1'b1;
                    wait_d    = WAIT_LOAD;
                end
                if (pf_wait_q && avm_readdatavalid) begin
                    hold_d    = avm_readdata;
                    hold_v_d  = 1'b1;
                    pf_wait_d = 1'b0;
                end else if (pf_wait_q && wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end
                if (ser_last) begin
                    cnt_d  = cnt_q - 9'd1;
                    addr_d = addr_q + ADDR_W'(1);
                    if (cnt_q == 9'd1) begin
                        state_d = CSUM;
                    end else if (hold_v_q || (pf_wait_q && avm_readdatavalid)) begin
                        ser_load      = 1'b1;
                        ser_from_hold = hold_v_q;
                        hold_v_d      = 1'b0;
                        pf_req_d      = (cnt_q > 9'd2);
                    end else if (pf_req_q && avm_waitrequest) begin
                        // Prefetch still stalled: hand the same address to RD_REQ.
                        pf_req_d = 1'b0;
                        state_d  = RD_REQ;
                    end else begin
                        pf_req_d  = 1'b0;
                        pf_wait_d = 1'b0;
                        state_d   = RD_WAIT;
                    end
                end
                if (pf_wait_q && !avm_readdatavalid && wait_q == '0) begin
                    err_d     = 1'b1;
                    pf_wait_d = 1'b0;
                    state_d   = FIN;
                end
`else
                if (ser_last) begin
                    cnt_d   = cnt_q - 9'd1;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = (cnt_q == 9'd1) ? CSUM : RD_REQ;
                end
`endif
            end
            CSUM: begin
                tx_valid = 1'b1;
                tx_data  = checksum(sum);
                if (tx_ready) state_d = FIN;
            end
            FIN: begin
                busy    = 1'b0;
                done    = 1'b1;
                error   = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

`ifdef FLASH_RD_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pf_req_q  <= 1'b0;
            pf_wait_q <= 1'b0;
            hold_v_q  <= 1'b0;
            hold_q    <= '0;
        end else begin
            pf_req_q  <= pf_req_d;
            pf_wait_q <= pf_wait_d;
            hold_v_q  <= hold_v_d;
            hold_q    <= hold_d;
        end
    end
`endif

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Bench for flash_read_sequencer: randomized flash slave and transmitter,
// reply frames predicted from the read-data command rules.
module tb_flash_read_sequencer;

    localparam int ADDR_W   = 17;
    localparam int WAIT_MAX = 1023;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [23:0]       start_addr = '0;
    logic [7:0]        word_count = '0;
    logic              busy, done, error;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest = 1'b0;
    logic [31:0]       avm_readdata = '0;
    logic              avm_readdatavalid = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b1;

    always #5 clk = ~clk;

    flash_read_sequencer #(.ADDR_W(ADDR_W), .RD_CMD(8'h56), .WAIT_MAX(WAIT_MAX)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .start_addr        (start_addr),
        .word_count        (word_count),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash contents: word 1 is pinned, the rest is an address hash.
    function automatic logic [31:0] fw(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(1)) return 32'h04030201;
        return {15'd0, a} * 32'h9E3779B1 + 32'h13572468;
    endfunction

    logic [7:0]        exp_b[$];
    logic [ADDR_W-1:0] exp_a[$];
    logic              exp_err = 1'b0;
    logic [7:0]        rx_log[$];
    logic [ADDR_W-1:0] addr_log[$];

    task automatic build_model(input logic [23:0] a, input logic [7:0] wc, input bit bad, input bit tmo);
        int n;
        logic [7:0] s;
        logic [31:0] w;
        logic [ADDR_W-1:0] ad;
        exp_b.delete();
        exp_a.delete();
        exp_err = bad || tmo;
        if (bad) return;
        n = (wc == 8'd0) ? 256 : int'(wc);
        exp_b.push_back(8'h56);
        exp_b.push_back(wc);
        if (tmo) begin
            exp_a.push_back(a[ADDR_W-1:0]);
            return;
        end
        for (int i = 0; i < n; i++) begin
            ad = ADDR_W'((int'(a[ADDR_W-1:0]) + i) % (1 << ADDR_W));
            exp_a.push_back(ad);
            w = fw(ad);
            for (int b = 0; b < 4; b++) exp_b.push_back(w[8*b +: 8]);
        end
        s = 8'h00;
        foreach (exp_b[k]) s = s + exp_b[k];
        exp_b.push_back(~s);
    endtask

    bit bp_en = 0, ws_en = 0, spur_en = 0, noresp = 0;
    bit active = 0, xfer_on = 0, done_seen = 0;
    bit prev_stall = 0, pend = 0;
    logic [7:0] prev_data = '0;
    logic [ADDR_W-1:0] pend_addr = '0;
    int lat = 0, cyc = 0, acc_cyc = 0, done_cyc = 0, tv_cnt = 0, ar_cnt = 0;

    // Flash slave, transmitter and the single compare process.
    always @(negedge clk) begin
        cyc++;
        tx_ready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (reset) begin
            pend = 0;
            prev_stall = 0;
        end
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
        if (pend) begin
            if (lat == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = fw(pend_addr);
                pend = 0;
            end else begin
                lat--;
            end
        end else if (spur_en && $urandom_range(0, 5) == 0) begin
            avm_readdatavalid = 1'b1;
        end
        avm_waitrequest = ws_en && ($urandom_range(0, 2) == 0);
        if (tx_valid) tv_cnt++;
        if (avm_read) ar_cnt++;
        if (avm_read && !avm_waitrequest && !reset) begin
            if (active) begin
                chk("one_outstanding", {31'd0, pend}, 32'd0);
                addr_log.push_back(avm_address);
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_addr: read at %0h but no read expected", avm_address);
                end else begin
                    chk("read_addr", avm_address, exp_a.pop_front());
                end
            end
            acc_cyc = cyc;
            pend = !noresp;
            pend_addr = avm_address;
            lat = $urandom_range(0, 2);
        end
        if (active && !reset) begin
            if (prev_stall) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                rx_log.push_back(tx_data);
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_byte: got %0h but no byte expected", tx_data);
                end else begin
                    chk("tx_byte", tx_data, exp_b.pop_front());
                end
            end
            if (xfer_on && !done) chk("busy_during", busy, 1);
            if (done) begin
                chk("done_error", error, exp_err);
                chk("bytes_left", exp_b.size(), 0);
                chk("reads_left", exp_a.size(), 0);
                chk("busy_at_done", busy, 0);
                done_cyc = cyc;
                done_seen = 1;
            end
        end
        prev_stall = active && tx_valid && !tx_ready;
        prev_data = tx_data;
    end

    task automatic begin_xfer(input logic [23:0] a, input logic [7:0] wc, input bit bad, input bit tmo);
        build_model(a, wc, bad, tmo);
        rx_log.delete();
        addr_log.delete();
        done_seen = 0;
        active = 1;
        @(posedge clk);
        #1;
        start_addr = a;
        word_count = wc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        xfer_on = 1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) @(posedge clk);
        xfer_on = 0;
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        active = 0;
        repeat (2) @(posedge clk);
    endtask

    logic [7:0] lit1 [7] = '{8'h56, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h9E};

    initial begin
        int tv0, ar0, gap;
        logic [23:0] ra;
        logic [7:0]  rc;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_avm_read", avm_read, 0);
        chk("rst_avm_address", avm_address, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // One word from address 1, no stalls.
        begin_xfer(24'h000001, 8'd1, 0, 0);
        wait_done(200);
        chk("t1_len", rx_log.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < rx_log.size()) chk("t1_literal", rx_log[i], lit1[i]);

        // Eight words with backpressure, stalls and stray data strobes.
        bp_en = 1; ws_en = 1; spur_en = 1;
        begin_xfer(24'h000010, 8'd8, 0, 0);
        wait_done(1000);
        chk("t2_len", rx_log.size(), 35);   // cmd + len + 32 payload + checksum
        chk("t2_reads", addr_log.size(), 8);

        // 256 words across the top of the address space.
        bp_en = 0; spur_en = 0;
        begin_xfer(24'h01FFF0, 8'd0, 0, 0);
        wait_done(8000);
        chk("t3_len", rx_log.size(), 1027);
        chk("t3_reads", addr_log.size(), 256);
        if (addr_log.size() > 16) begin
            chk("t3_addr_top", addr_log[15], 17'h1FFFF);
            chk("t3_addr_wrap", addr_log[16], 17'h00000);
        end
        ws_en = 0;

        // Out-of-range address.
        tv0 = tv_cnt; ar0 = ar_cnt;
        begin_xfer(24'h020000, 8'd5, 1, 0);
        wait_done(50);
        chk("t4_no_tx_valid", tv_cnt - tv0, 0);
        chk("t4_no_avm_read", ar_cnt - ar0, 0);

        // Flash never answers; a second start meanwhile must be ignored.
        noresp = 1;
        begin_xfer(24'h000123, 8'd1, 0, 1);
        repeat (100) @(posedge clk);
        #1;
        start_addr = 24'h000001;
        word_count = 8'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(WAIT_MAX + 200);
        gap = done_cyc - acc_cyc;
        chk("t5_timeout_window", (gap >= WAIT_MAX && gap <= WAIT_MAX + 2) ? 1 : 0, 1);
        chk("t5_idle_after", busy, 0);
        noresp = 0;

        // Random transfers.
        for (int t = 0; t < 4; t++) begin
            ra = 24'($urandom_range(0, 32'h1FFFF));
            rc = 8'($urandom_range(1, 6));
            bp_en = $urandom_range(0, 1);
            ws_en = $urandom_range(0, 1);
            spur_en = $urandom_range(0, 1);
            begin_xfer(ra, rc, 0, 0);
            wait_done(1000);
            chk("rand_len", rx_log.size(), 3 + 4 * int'(rc));
        end
        bp_en = 0; ws_en = 0; spur_en = 0;

        // Reset in the middle of the first payload word, then a clean frame.
        begin_xfer(24'h000123, 8'd4, 0, 0);
        for (int i = 0; i < 200 && rx_log.size() < 4; i++) @(posedge clk);
        chk("t6_reached_payload", (rx_log.size() >= 4) ? 1 : 0, 1);
        #1;
        active = 0;
        xfer_on = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_tx_valid", tx_valid, 0);
        chk("t6_avm_read", avm_read, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        begin_xfer(24'h000123, 8'd4, 0, 0);
        wait_done(500);
        chk("t6_len", rx_log.size(), 19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
